// File: rtl/delta_bit_packer.sv
// delta_bit_packer: packs variable-length delta codes LSB-first into DATA_W-bit
// words through a shifting accumulator. A flush emits the zero-padded tail word.
module delta_bit_packer #(
  parameter int DATA_W     = 32,
  parameter int CODE_W_MAX = 11,
  parameter int LEN_W      = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  CLK,
  input  logic                  RST_n,
  input  logic [CODE_W_MAX-1:0] in_code,
  input  logic [LEN_W-1:0]      in_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  flush_done,
  output logic [CNT_W-1:0]      word_cnt
);

  localparam int ACC_W  = DATA_W + CODE_W_MAX;
  localparam int FILL_W = $clog2(ACC_W);

  typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

  state_t              state_reg;
  logic [ACC_W-1:0]    acc_reg;
  logic [ACC_W-1:0]    acc_next;
  logic [FILL_W-1:0]   fill_reg;
  logic [FILL_W-1:0]   fill_next;
  logic [LEN_W-1:0]    eff_len;
  logic [CODE_W_MAX-1:0] masked_code;
  logic                out_free;
  logic                drain;
  logic                flush_tail;
  logic                accept;
  logic [ACC_W-1:0]    acc_drained;
  logic [FILL_W-1:0]   fill_drained;

  // Oversized lengths saturate at the widest legal code.
  assign eff_len = (in_len > LEN_W'(CODE_W_MAX)) ? LEN_W'(CODE_W_MAX) : in_len;

  // Clear every code bit at or above the effective length.
  generate
    for (genvar gi = 0; gi < CODE_W_MAX; gi++) begin : g_mask
      assign masked_code[gi] = in_code[gi] & (eff_len > LEN_W'(gi));
    end
  endgenerate

  assign out_free   = !out_valid || out_ready;
  assign drain      = (fill_reg >= FILL_W'(DATA_W)) && out_free;
  assign flush_tail = (state_reg == FLUSH) && (fill_reg < FILL_W'(DATA_W)) && out_free;
  assign in_ready   = (state_reg == RUN) && ((fill_reg < FILL_W'(DATA_W)) || drain);
  assign accept     = in_valid && in_ready;

  // Next accumulator: drop a drained word, then append the accepted code above the remaining bits.
  always_comb begin
    acc_drained  = acc_reg;
    fill_drained = fill_reg;
    if (drain) begin
      acc_drained  = acc_reg >> DATA_W;
      fill_drained = fill_reg - FILL_W'(DATA_W);
    end
    acc_next  = acc_drained;
    fill_next = fill_drained;
    if (accept) begin
      acc_next  = acc_drained | (ACC_W'(masked_code) << fill_drained);
      fill_next = fill_drained + FILL_W'(eff_len);
    end
    if (flush_tail) begin
      acc_next  = '0;
      fill_next = '0;
    end
  end

  // Accumulator, output register, word counter and flush state machine.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_reg  <= RUN;
      acc_reg    <= '0;
      fill_reg   <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      flush_done <= 1'b0;
      word_cnt   <= '0;
    end else begin
      acc_reg    <= acc_next;
      fill_reg   <= fill_next;
      flush_done <= (state_reg == DONE);

      if (drain) begin
        out_data  <= acc_reg[DATA_W-1:0];
        out_valid <= 1'b1;
        out_last  <= 1'b0;
        word_cnt  <= word_cnt + CNT_W'(1);
      end else if (flush_tail && (fill_reg != '0)) begin
        // Bits above fill are already zero, so the tail word is naturally padded.
        out_data  <= acc_reg[DATA_W-1:0];
        out_valid <= 1'b1;
        out_last  <= 1'b1;
        word_cnt  <= word_cnt + CNT_W'(1);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end

      case (state_reg)
        RUN:     if (flush) state_reg <= FLUSH;
        FLUSH:   if (flush_tail) state_reg <= DONE;
        DONE:    state_reg <= RUN;
        default: state_reg <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_delta_bit_packer.sv
// Directed bench for delta_bit_packer: table of per-cycle vectors plus
// hand-written sequences for packing, back-pressure and mid-flush reset.
module tb_delta_bit_packer;

  logic        CLK = 1'b0;
  logic        RST_n;
  logic [10:0] in_code;
  logic [3:0]  in_len;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;
  logic        flush_done;
  logic [15:0] word_cnt;

  delta_bit_packer #(
    .DATA_W(32), .CODE_W_MAX(11), .LEN_W(4), .CNT_W(16)
  ) dut (
    .CLK(CLK), .RST_n(RST_n),
    .in_code(in_code), .in_len(in_len), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .flush_done(flush_done), .word_cnt(word_cnt)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Inputs applied at a negedge; expectations describe outputs 1 ns later,
  // i.e. the state left by all previous rising edges.
  typedef struct packed {
    logic [10:0] code;
    logic [3:0]  len;
    logic        vld;
    logic        fl;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_data;
    logic        e_last;
    logic        e_fd;
    logic [15:0] e_wc;
  } vec_t;

  function automatic vec_t mk(input logic [10:0] c, input logic [3:0] l, input logic v,
                              input logic f, input logic eir, input logic eov,
                              input logic [31:0] ed, input logic el, input logic efd,
                              input logic [15:0] ewc);
    vec_t r;
    r.code = c; r.len = l; r.vld = v; r.fl = f;
    r.e_ir = eir; r.e_ov = eov; r.e_data = ed; r.e_last = el; r.e_fd = efd; r.e_wc = ewc;
    return r;
  endfunction

  localparam int NV = 26;
  vec_t vecs [NV];

  initial begin
    int          ov_cycles;
    logic        ir_ok;
    logic [31:0] got;
    logic [95:0] pat;
    int          idx;
    int          nw;
    logic [31:0] words [3];
    logic [31:0] held;
    logic        have_held;
    logic        stable_ok;
    logic        resume_ok;

    // Three 11-bit codes then flush: 0xFFC007FF, then tail 0x00000001 with out_last.
    vecs[0]  = mk(11'h7FF, 4'd11, 1, 0, 1, 0, 32'h0,        0, 0, 16'd0);
    vecs[1]  = mk(11'h000, 4'd11, 1, 0, 1, 0, 32'h0,        0, 0, 16'd0);
    vecs[2]  = mk(11'h7FF, 4'd11, 1, 1, 1, 0, 32'h0,        0, 0, 16'd0);
    vecs[3]  = mk(11'h000, 4'd0,  0, 0, 0, 0, 32'h0,        0, 0, 16'd0);
    vecs[4]  = mk(11'h000, 4'd0,  0, 0, 0, 1, 32'hFFC007FF, 0, 0, 16'd1);
    vecs[5]  = mk(11'h000, 4'd0,  0, 0, 0, 1, 32'h00000001, 1, 0, 16'd2);
    vecs[6]  = mk(11'h000, 4'd0,  0, 0, 1, 0, 32'h0,        0, 1, 16'd2);
    vecs[7]  = mk(11'h000, 4'd0,  0, 0, 1, 0, 32'h0,        0, 0, 16'd2);
    // in_len=15 saturates to 11; code accepted together with flush.
    vecs[8]  = mk(11'h7FF, 4'd15, 1, 1, 1, 0, 32'h0,        0, 0, 16'd2);
    vecs[9]  = mk(11'h000, 4'd0,  0, 0, 0, 0, 32'h0,        0, 0, 16'd2);
    vecs[10] = mk(11'h000, 4'd0,  0, 0, 0, 1, 32'h000007FF, 1, 0, 16'd3);
    vecs[11] = mk(11'h000, 4'd0,  0, 0, 1, 0, 32'h0,        0, 1, 16'd3);
    // Masking: len 3 of 0x7FF -> 0x7, len 0 adds nothing, len 5 of 0x0A at bit 3 -> 0x57.
    vecs[12] = mk(11'h7FF, 4'd3,  1, 0, 1, 0, 32'h0,        0, 0, 16'd3);
    vecs[13] = mk(11'h7FF, 4'd0,  1, 0, 1, 0, 32'h0,        0, 0, 16'd3);
    vecs[14] = mk(11'h00A, 4'd5,  1, 1, 1, 0, 32'h0,        0, 0, 16'd3);
    vecs[15] = mk(11'h000, 4'd0,  0, 0, 0, 0, 32'h0,        0, 0, 16'd3);
    vecs[16] = mk(11'h000, 4'd0,  0, 0, 0, 1, 32'h00000057, 1, 0, 16'd4);
    vecs[17] = mk(11'h000, 4'd0,  0, 0, 1, 0, 32'h0,        0, 1, 16'd4);
    // Flush with empty accumulator: no word, flush_done two cycles after flush.
    vecs[18] = mk(11'h7FF, 4'd0,  1, 0, 1, 0, 32'h0,        0, 0, 16'd4);
    vecs[19] = mk(11'h000, 4'd0,  0, 1, 1, 0, 32'h0,        0, 0, 16'd4);
    vecs[20] = mk(11'h000, 4'd0,  0, 0, 0, 0, 32'h0,        0, 0, 16'd4);
    vecs[21] = mk(11'h000, 4'd0,  0, 0, 0, 0, 32'h0,        0, 0, 16'd4);
    vecs[22] = mk(11'h000, 4'd0,  0, 0, 1, 0, 32'h0,        0, 1, 16'd4);
    vecs[23] = mk(11'h000, 4'd0,  0, 0, 1, 0, 32'h0,        0, 0, 16'd4);
    vecs[24] = mk(11'h000, 4'd0,  0, 0, 1, 0, 32'h0,        0, 0, 16'd4);
    vecs[25] = mk(11'h000, 4'd0,  0, 0, 1, 0, 32'h0,        0, 0, 16'd4);

    // Reset state.
    RST_n = 1'b0; in_code = '0; in_len = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    #12;
    chk("reset_out_valid",  32'(out_valid),  32'd0);
    chk("reset_out_last",   32'(out_last),   32'd0);
    chk("reset_out_data",   out_data,        32'd0);
    chk("reset_flush_done", 32'(flush_done), 32'd0);
    chk("reset_word_cnt",   32'(word_cnt),   32'd0);
    chk("reset_in_ready",   32'(in_ready),   32'd1);
    @(negedge CLK);
    RST_n = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < NV; i++) begin
      @(negedge CLK);
      in_code = vecs[i].code; in_len = vecs[i].len; in_valid = vecs[i].vld; flush = vecs[i].fl;
      #1;
      $display("row %0d: code=%03h len=%0d vld=%0b fl=%0b -> ir=%0b ov=%0b data=%08h last=%0b fd=%0b wc=%0d",
               i, in_code, in_len, in_valid, flush, in_ready, out_valid, out_data, out_last,
               flush_done, word_cnt);
      chk($sformatf("row%0d_in_ready", i),   32'(in_ready),   32'(vecs[i].e_ir));
      chk($sformatf("row%0d_out_valid", i),  32'(out_valid),  32'(vecs[i].e_ov));
      chk($sformatf("row%0d_out_last", i),   32'(out_last),   32'(vecs[i].e_last));
      chk($sformatf("row%0d_flush_done", i), 32'(flush_done), 32'(vecs[i].e_fd));
      chk($sformatf("row%0d_word_cnt", i),   32'(word_cnt),   32'(vecs[i].e_wc));
      if (vecs[i].e_ov) chk($sformatf("row%0d_out_data", i), out_data, vecs[i].e_data);
    end

    // 32 one-bit codes alternating 1/0 -> single word 0x55555555.
    ir_ok = 1'b1; ov_cycles = 0; got = '0;
    for (int i = 0; i < 35; i++) begin
      @(negedge CLK);
      in_valid = (i < 32); in_len = 4'd1; in_code = (i % 2 == 0) ? 11'd1 : 11'd0; flush = 1'b0;
      #1;
      if (!in_ready) ir_ok = 1'b0;
      if (out_valid) begin ov_cycles++; got = out_data; end
    end
    $display("alternating: word=%08h ov_cycles=%0d wc=%0d", got, ov_cycles, word_cnt);
    chk("alt_word",      got,               32'h55555555);
    chk("alt_ov_cycles", 32'(ov_cycles),    32'd1);
    chk("alt_in_ready",  32'(ir_ok),        32'd1);
    chk("alt_word_cnt",  32'(word_cnt),     32'd5);

    // Back-pressure: 96 one-bit codes, out_ready held low until cycle 70.
    pat = 96'hDEADBEEF_01234567_89ABCDEF;
    idx = 0; nw = 0; have_held = 1'b0; stable_ok = 1'b1; resume_ok = 1'b1; held = '0;
    for (int cyc = 0; cyc < 300 && nw < 3; cyc++) begin
      @(negedge CLK);
      in_valid  = (idx < 96);
      in_code   = {10'd0, pat[idx % 96]};
      in_len    = 4'd1;
      out_ready = (cyc >= 70);
      #1;
      if (cyc == 68) begin
        chk("bp_in_ready_low", 32'(in_ready),  32'd0);
        chk("bp_out_valid",    32'(out_valid), 32'd1);
        chk("bp_held_data",    out_data,       pat[31:0]);
      end
      if (out_valid && !out_ready) begin
        if (!have_held) begin held = out_data; have_held = 1'b1; end
        else if (out_data !== held) stable_ok = 1'b0;
      end
      if (cyc >= 70 && in_valid && !in_ready) resume_ok = 1'b0;
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) begin
        words[nw] = out_data;
        $display("bp word %0d: %08h at cycle %0d", nw, out_data, cyc);
        nw++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_word_count", 32'(nw), 32'd3);
    if (nw == 3) begin
      chk("bp_word0", words[0], pat[31:0]);
      chk("bp_word1", words[1], pat[63:32]);
      chk("bp_word2", words[2], pat[95:64]);
    end
    chk("bp_stable",   32'(stable_ok), 32'd1);
    chk("bp_resume",   32'(resume_ok), 32'd1);
    chk("bp_word_cnt", 32'(word_cnt),  32'd8);

    // Reset asserted mid-flush while a word is held.
    @(negedge CLK);
    out_ready = 1'b0; in_valid = 1'b1; in_len = 4'd11; in_code = 11'h7FF; flush = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    flush = 1'b1;
    @(negedge CLK);
    in_valid = 1'b0; flush = 1'b0;
    @(negedge CLK);
    #1;
    chk("mid_flush_out_valid", 32'(out_valid), 32'd1);
    chk("mid_flush_word_cnt",  32'(word_cnt),  32'd9);
    #2;
    RST_n = 1'b0;
    #1;
    $display("mid-flush reset: ov=%0b last=%0b fd=%0b wc=%0d data=%08h",
             out_valid, out_last, flush_done, word_cnt, out_data);
    chk("rst_out_valid",  32'(out_valid),  32'd0);
    chk("rst_out_last",   32'(out_last),   32'd0);
    chk("rst_flush_done", 32'(flush_done), 32'd0);
    chk("rst_word_cnt",   32'(word_cnt),   32'd0);
    chk("rst_out_data",   out_data,        32'd0);
    @(negedge CLK);
    RST_n = 1'b1; out_ready = 1'b1;
    @(negedge CLK);
    in_valid = 1'b1; in_len = 4'd3; in_code = 11'h005; flush = 1'b1;
    @(negedge CLK);
    in_valid = 1'b0; flush = 1'b0;
    @(negedge CLK);
    #1;
    $display("post-reset word: ov=%0b data=%08h last=%0b wc=%0d", out_valid, out_data, out_last, word_cnt);
    chk("post_rst_out_valid", 32'(out_valid), 32'd1);
    chk("post_rst_out_data",  out_data,       32'h00000005);
    chk("post_rst_out_last",  32'(out_last),  32'd1);
    chk("post_rst_word_cnt",  32'(word_cnt),  32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
